// File: rtl/display_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_controller
// Purpose  : Scans a 4-digit common-anode display through one 7-segment
//            decoder, latching time/message inputs once per frame.
//            Optional blinking of FIN/PA messages when BLINK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_controller #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_units,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_units,
    output logic [3:0] dec_code,
    output logic [3:0] an,
    output logic       dp,
    output logic       frame_start
);

    localparam int              PW           = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]   C_PRESC_LAST = PW'(REFRESH_DIV - 1);

    localparam logic [1:0] C_MODE_TIME = 2'b00;
    localparam logic [1:0] C_MODE_FIN  = 2'b01;
    localparam logic [1:0] C_MODE_PA   = 2'b10;
    localparam logic [1:0] C_MODE_OFF  = 2'b11;

    localparam logic [3:0] C_CODE_F     = 4'hA;
    localparam logic [3:0] C_CODE_I     = 4'hB;
    localparam logic [3:0] C_CODE_N     = 4'hC;
    localparam logic [3:0] C_CODE_P     = 4'hD;
    localparam logic [3:0] C_CODE_A     = 4'hE;
    localparam logic [3:0] C_CODE_BLANK = 4'hF;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    snap_mode_q, snap_mode_d;
    logic [15:0]   snap_digits_q, snap_digits_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    dec_code_q, dec_code_d;
    logic          dp_q, dp_d;
    logic          frame_start_q, frame_start_d;

    logic          w_tick;
    logic          w_frame;
    logic [3:0]    w_digit;
    logic [3:0]    w_an;
    logic [3:0]    w_code;
    logic          w_dp;
    logic          w_blink_off;

    // Prescaler, digit rotation and per-frame snapshot
    always_comb begin
        w_tick        = (presc_q == C_PRESC_LAST);
        w_frame       = w_tick && (idx_q == 2'd3);
        presc_d       = w_tick ? '0 : presc_q + PW'(1);
        idx_d         = w_tick ? idx_q + 2'd1 : idx_q;
        snap_mode_d   = snap_mode_q;
        snap_digits_d = snap_digits_q;
        if (w_frame) begin
            snap_mode_d   = mode;
            snap_digits_d = {min_tens, min_units, sec_tens, sec_units};
        end
        frame_start_d = w_frame;
        an_d          = w_tick ? w_an   : an_q;
        dec_code_d    = w_tick ? w_code : dec_code_q;
        dp_d          = w_tick ? w_dp   : dp_q;
    end

    // Decode the slot being entered, so the snapshot and index used are the
    // values that become current on this tick.
    always_comb begin
        w_digit = snap_digits_d[{idx_d, 2'b00} +: 4];
        w_an    = ~(4'b0001 << idx_d);
        w_code  = C_CODE_BLANK;
        w_dp    = 1'b1;
        case (snap_mode_d)
            C_MODE_TIME: begin
                if ((w_digit <= 4'd9) && !((idx_d == 2'd3) && (w_digit == 4'd0))) begin
                    w_code = w_digit;
                end
                w_dp = (idx_d != 2'd2);
            end
            C_MODE_FIN: begin
                case (idx_d)
                    2'd0:    w_code = C_CODE_N;
                    2'd1:    w_code = C_CODE_I;
                    2'd2:    w_code = C_CODE_F;
                    default: w_code = C_CODE_BLANK;
                endcase
            end
            C_MODE_PA: begin
                case (idx_d)
                    2'd3:    w_code = C_CODE_P;
                    2'd2:    w_code = C_CODE_A;
                    default: w_code = C_CODE_BLANK;
                endcase
            end
            C_MODE_OFF: w_an = 4'b1111;
            default:    w_an = 4'b1111;
        endcase
        if (w_blink_off && ((snap_mode_d == C_MODE_FIN) || (snap_mode_d == C_MODE_PA))) begin
            w_an = 4'b1111;
        end
    end

`ifdef BLINK_EN
    localparam int            FW           = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] C_BLINK_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;

    // Phase only moves at a frame boundary; a new message restarts lit
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (w_frame) begin
            if (mode != snap_mode_q) begin
                blink_cnt_d   = '0;
                blink_phase_d = 1'b0;
            end else if (blink_cnt_q == C_BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign w_blink_off = blink_phase_d;
`else
    logic w_unused_blink_frames;

    assign w_blink_off           = 1'b0;
    assign w_unused_blink_frames = ^BLINK_FRAMES;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q       <= '0;
            idx_q         <= 2'd3;
            snap_mode_q   <= C_MODE_OFF;
            snap_digits_q <= '0;
            an_q          <= 4'b1111;
            dec_code_q    <= C_CODE_BLANK;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            snap_mode_q   <= snap_mode_d;
            snap_digits_q <= snap_digits_d;
            an_q          <= an_d;
            dec_code_q    <= dec_code_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign dec_code    = dec_code_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire
